// File: rtl/driver_cell_ctrl_pkg.sv
// Shared types and default geometry for the segmented DAC driver-cell controller.
package driver_cell_ctrl_pkg;

   localparam int DEF_N_BIN      = 7;
   localparam int DEF_N_THERM    = 17;
   localparam int DEF_CODE_W     = 12;
   localparam int DEF_CODE_MAX   = 2303;
   localparam int DEF_IDLE_CODE  = 1152;
   localparam int DEF_SETTLE_CYC = 16;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_PWRUP = 2'd1,
      ST_RUN   = 2'd2,
      ST_PWRDN = 2'd3
   } ctrl_state_t;

   typedef logic [DEF_N_THERM-1:0] therm_t;
   typedef logic [DEF_N_BIN-1:0]   bin_t;

endpackage

// File: rtl/driver_cell_seg_enc.sv
// Combinational segmented encoder: saturates a code at full scale, then splits it
// into a thermometer MSB field and a binary LSB field.
module driver_cell_seg_enc
   import driver_cell_ctrl_pkg::*;
#(
   parameter int N_BIN    = DEF_N_BIN,
   parameter int N_THERM  = DEF_N_THERM,
   parameter int CODE_W   = DEF_CODE_W,
   parameter int CODE_MAX = DEF_CODE_MAX
) (
   input  logic [CODE_W-1:0]  code,
   output logic [N_THERM-1:0] therm,
   output logic [N_BIN-1:0]   bin
);

   localparam logic [CODE_W-1:0] MAX_C = CODE_W'(CODE_MAX);

   logic [CODE_W-1:0] w_c;
   logic [CODE_W-1:0] w_t;

   assign w_c = (code > MAX_C) ? MAX_C : code;
   assign w_t = w_c >> N_BIN;
   assign bin = w_c[N_BIN-1:0];

   always_comb begin
      therm = '0;
      for (int i = 0; i < N_THERM; i++) begin
         therm[i] = (CODE_W'(i) < w_t);
      end
   end

endmodule

// File: rtl/driver_cell_ctrl.sv
// Power sequencing, sample intake and registered line drive for the DAC driver cell.
module driver_cell_ctrl
   import driver_cell_ctrl_pkg::*;
#(
   parameter int N_BIN      = DEF_N_BIN,
   parameter int N_THERM    = DEF_N_THERM,
   parameter int CODE_W     = DEF_CODE_W,
   parameter int CODE_MAX   = DEF_CODE_MAX,
   parameter int IDLE_CODE  = DEF_IDLE_CODE,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               supply_ok,
   input  logic [CODE_W-1:0]  sample_in,
   input  logic               sample_valid,
   output logic               sample_ready,
   output logic [N_BIN-1:0]   datain,
   output logic [N_BIN-1:0]   datainb,
   output logic [N_THERM-1:0] datatherm,
   output logic [N_THERM-1:0] datathermb,
   output logic               pdb,
   output logic [1:0]         state_o,
   output logic               sat,
   output logic               fault,
   output logic [15:0]        underflow_cnt,
   input  logic               clr_flags
);

   localparam int CNT_W = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

   ctrl_state_t        r_state;
   ctrl_state_t        w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_accept;
   logic               w_underrun;
   logic               w_over;
   logic [CODE_W-1:0]  w_code;
   logic [N_THERM-1:0] w_therm;
   logic [N_BIN-1:0]   w_bin;

   assign w_accept   = sample_ready && sample_valid;
   assign w_underrun = (r_state == ST_RUN) && !w_accept;
   assign w_over     = sample_in > CODE_W'(CODE_MAX);
   assign w_code     = (w_next == ST_RUN) ? sample_in : CODE_W'(IDLE_CODE);
   assign state_o    = r_state;

   driver_cell_seg_enc #(
      .N_BIN    (N_BIN),
      .N_THERM  (N_THERM),
      .CODE_W   (CODE_W),
      .CODE_MAX (CODE_MAX)
   ) u_enc (
      .code  (w_code),
      .therm (w_therm),
      .bin   (w_bin)
   );

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         ST_OFF: begin
            if (en && supply_ok) begin
               w_next     = ST_PWRUP;
               w_cnt_next = '0;
            end
         end
         ST_PWRUP: begin
            if (!en) begin
               w_next     = ST_PWRDN;
               w_cnt_next = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_next = ST_RUN;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (!en) begin
               w_next     = ST_PWRDN;
               w_cnt_next = '0;
            end
         end
         default: begin
            if (r_cnt == CNT_LAST) begin
               w_next = ST_OFF;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
      endcase
      // A supply fault overrides every other transition.
      if (r_state != ST_OFF && !supply_ok) begin
         w_next = ST_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_OFF;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Line drive follows the state being entered so outputs are aligned with state_o.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_ready <= 1'b0;
         pdb          <= 1'b0;
         datain       <= '0;
         datainb      <= '1;
         datatherm    <= '0;
         datathermb   <= '1;
      end else begin
         sample_ready <= (w_next == ST_RUN);
         case (w_next)
            ST_OFF: begin
               pdb        <= 1'b0;
               datain     <= '0;
               datainb    <= '1;
               datatherm  <= '0;
               datathermb <= '1;
            end
            ST_RUN: begin
               pdb <= 1'b1;
               if (w_accept) begin
                  datain     <= w_bin;
                  datainb    <= ~w_bin;
                  datatherm  <= w_therm;
                  datathermb <= ~w_therm;
               end
            end
            default: begin
               pdb        <= 1'b1;
               datain     <= w_bin;
               datainb    <= ~w_bin;
               datatherm  <= w_therm;
               datathermb <= ~w_therm;
            end
         endcase
      end
   end

   // Sticky flags: a set event in the same cycle as clr_flags survives the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat           <= 1'b0;
         fault         <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         if (w_accept && w_over) begin
            sat <= 1'b1;
         end else if (clr_flags) begin
            sat <= 1'b0;
         end
         if (r_state != ST_OFF && !supply_ok) begin
            fault <= 1'b1;
         end else if (clr_flags) begin
            fault <= 1'b0;
         end
         if (clr_flags) begin
            underflow_cnt <= w_underrun ? 16'd1 : 16'd0;
         end else if (w_underrun && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_driver_cell_ctrl.sv
// Bench for driver_cell_ctrl: directed power/sample sequences then random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_driver_cell_ctrl;

   localparam int SETTLE = 16;
   localparam int CMAX   = 2303;
   localparam int IDLE   = 1152;

   logic        clk = 1'b0;
   logic        rst, en, supply_ok, sample_valid, clr_flags;
   logic [11:0] sample_in;
   logic        sample_ready, pdb, sat, fault;
   logic [6:0]  datain, datainb;
   logic [16:0] datatherm, datathermb;
   logic [1:0]  state_o;
   logic [15:0] underflow_cnt;

   driver_cell_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .supply_ok     (supply_ok),
      .sample_in     (sample_in),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .datain        (datain),
      .datainb       (datainb),
      .datatherm     (datatherm),
      .datathermb    (datathermb),
      .pdb           (pdb),
      .state_o       (state_o),
      .sat           (sat),
      .fault         (fault),
      .underflow_cnt (underflow_cnt),
      .clr_flags     (clr_flags)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: phase names as ints, time spent in the current phase, and the code on the lines.
   int m_st;
   int m_spent;
   int m_code;
   int m_sat, m_fault, m_uf;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
   endtask

   function automatic int sat_code(input int code);
      return (code > CMAX) ? CMAX : code;
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit ok, input bit v,
                             input int code, input bit clr);
      bit acc, miss;
      if (r) begin
         m_st = 0; m_spent = 0; m_code = 0; m_sat = 0; m_fault = 0; m_uf = 0;
         return;
      end
      acc  = (m_st == 2) && v;
      miss = (m_st == 2) && !v;
      if (acc && code > CMAX) m_sat = 1;
      else if (clr) m_sat = 0;
      if (m_st != 0 && !ok) m_fault = 1;
      else if (clr) m_fault = 0;
      if (clr) m_uf = miss ? 1 : 0;
      else if (miss && m_uf < 65535) m_uf++;
      if (m_st != 0 && !ok) begin
         m_st = 0;
         return;
      end
      case (m_st)
         0: if (e && ok) begin m_st = 1; m_spent = 0; end
         1: begin
            if (!e) begin m_st = 3; m_spent = 0; end
            else begin
               m_spent++;
               if (m_spent == SETTLE) begin m_st = 2; m_code = IDLE; end
            end
         end
         2: begin
            if (acc) m_code = code;
            if (!e) begin m_st = 3; m_spent = 0; end
         end
         default: begin
            m_spent++;
            if (m_spent == SETTLE) m_st = 0;
         end
      endcase
   endtask

   task automatic check_outputs();
      int c, th, bn;
      chk_eq("state", state_o, m_st);
      chk_eq("pdb", pdb, m_st != 0);
      chk_eq("ready", sample_ready, m_st == 2);
      if (m_st == 0) begin
         th = 0; bn = 0;
      end else begin
         c  = sat_code((m_st == 2) ? m_code : IDLE);
         th = (1 << (c / 128)) - 1;
         bn = c % 128;
      end
      chk_eq("therm", datatherm, th);
      chk_eq("thermb", datathermb, (~th) & 32'h1FFFF);
      chk_eq("bin", datain, bn);
      chk_eq("binb", datainb, (~bn) & 32'h7F);
      chk_eq("sat", sat, m_sat);
      chk_eq("fault", fault, m_fault);
      chk_eq("uf", underflow_cnt, m_uf);
   endtask

   task automatic step(input bit r, input bit e, input bit ok, input bit v,
                       input int code, input bit clr);
      rst = r; en = e; supply_ok = ok; sample_valid = v;
      sample_in = code[11:0]; clr_flags = clr;
      @(posedge clk);
      model_edge(r, e, ok, v, code, clr);
      #1;
      check_outputs();
   endtask

   task automatic idle_cycles(input int n, input bit e, input bit ok);
      for (int i = 0; i < n; i++) step(0, e, ok, 0, 0, 0);
   endtask

   initial begin
      rst = 1; en = 0; supply_ok = 1; sample_valid = 0; sample_in = '0; clr_flags = 0;
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      // power-up settle into RUN
      idle_cycles(SETTLE + 2, 1, 1);
      step(0, 1, 1, 1, 12'h000, 0);
      step(0, 1, 1, 1, 12'h8FF, 0);
      step(0, 1, 1, 1, 12'h47F, 0);
      step(0, 1, 1, 1, 12'hFFF, 0);
      step(0, 1, 1, 1, 12'h123, 0);
      step(0, 1, 1, 1, 12'h200, 1);
      idle_cycles(5, 1, 1);
      step(0, 1, 1, 1, 12'h300, 1);
      // orderly power-down
      idle_cycles(SETTLE + 3, 0, 1);
      // supply fault during PWRUP, then during RUN
      idle_cycles(5, 1, 1);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 1);
      idle_cycles(SETTLE + 4, 1, 1);
      step(0, 1, 0, 1, 12'h100, 0);
      idle_cycles(2, 1, 1);
      // reset in the middle of power-down
      idle_cycles(SETTLE + 2, 1, 1);
      idle_cycles(4, 0, 1);
      step(1, 0, 1, 0, 0, 0);
      idle_cycles(2, 0, 1);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < 95,
              $urandom_range(0, 199) != 0,
              $urandom_range(0, 9) < 7,
              int'($urandom_range(0, 4095)),
              $urandom_range(0, 99) < 3);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
